regread_arbiter: RTL

- Shares one combinational register-file read port (32 entries, 5-bit select, 32:1 mux tree per data bit) among NUM_REQ requesters.
- Requesters are pipeline read clients, e.g. decode Rn, decode Rm/Rd, debug/trace.
- Grants round-robin, drives the read-port select, and registers the read data into a one-entry response buffer with valid/ready backpressure.
- Sits between the pipeline read clients and the register file.

---
 rtl/regread_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regread_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/regread_pkg.sv
// rtl/regread_pkg.sv - shared constants and types for the register read-port arbiter
package regread_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ADDR_W          = 5;
  localparam int DATA_W          = 64;
  localparam int ZERO_REG        = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Scan from the pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (enable && !found && req[cand]) begin
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regread_arbiter.sv
// rtl/regread_arbiter.sv - shares one register-file read port among NUM_REQ clients
module regread_arbiter #(
  parameter int NUM_REQ  = regread_pkg::NUM_REQ_DEFAULT,
  parameter int ADDR_W   = regread_pkg::ADDR_W,
  parameter int DATA_W   = regread_pkg::DATA_W,
  parameter int ZERO_REG = regread_pkg::ZERO_REG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [ADDR_W-1:0]          rf_sel,
  input  logic [DATA_W-1:0]          rf_data,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       rsp_ready
);

  import regread_pkg::*;

  localparam int   ID_W     = $clog2(NUM_REQ);
  localparam logic ST_EMPTY = 1'(EMPTY);
  localparam logic ST_FULL  = 1'(FULL);

  logic              state;
  logic              can_issue;
  logic              grant;
  logic [ID_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  // A full buffer may still issue when the consumer drains it this cycle.
  assign rsp_valid = (state == ST_FULL);
  assign can_issue = !rsp_valid || rsp_ready;
  assign grant     = |req_ready;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .enable  (can_issue),
    .advance (grant),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  // Idle select is pinned to zero so the read port never toggles on stale addresses.
  always_comb begin
    rf_sel = '0;
    if (grant) begin
      rf_sel = addr_arr[gnt_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (grant) begin
            state    <= ST_FULL;
            rsp_id   <= gnt_idx;
            rsp_data <= (rf_sel == ADDR_W'(ZERO_REG)) ? '0 : rf_data;
          end
        end
        default: begin
          if (grant) begin
            rsp_id   <= gnt_idx;
            rsp_data <= (rf_sel == ADDR_W'(ZERO_REG)) ? '0 : rf_data;
          end else if (rsp_ready) begin
            state <= ST_EMPTY;
          end
        end
      endcase
    end
  end

endmodule
